// File: rtl/keyed_stage_fsm.sv
// Key-locked multi-stage sequence controller with a shadow path and a trap on repeated wrong keys.
// Optional: define KEYED_FSM_RELOCK_EN so a correct key at the lock point clears the wrong-visit count.
module keyed_stage_fsm #(
    parameter int                NUM_STAGES = 8,
    parameter int                KEY_W      = 4,
    parameter logic [KEY_W-1:0]  KEY_VALUE  = 4'hA,
    parameter int                LOCK_STAGE = 3,
    parameter int                TRAP_LIMIT = 5,
    parameter int                CNT_W      = 8,
    localparam int               IDX_W      = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  advance,
    input  logic                  abort,
    input  logic [KEY_W-1:0]      key,
    output logic [NUM_STAGES-1:0] stage_onehot,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      pass_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGE,
        S_SHADOW,
        S_TRAP,
        S_DONE
    } state_t;

    localparam logic [IDX_W-1:0] PRE_IDX  = IDX_W'(LOCK_STAGE - 1);
    localparam logic [IDX_W-1:0] LOCK_IDX = IDX_W'(LOCK_STAGE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0] SUCC_IDX = IDX_W'(LOCK_STAGE + 1);
    localparam logic [7:0]       TRAP_LIM = 8'(TRAP_LIMIT);
    localparam bit               LOCK_IS_LAST = (LOCK_STAGE == NUM_STAGES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] stage_q, stage_d;
    logic [7:0]       wrong_q, wrong_d;
    logic [CNT_W-1:0] pass_q,  pass_d;
    logic [7:0]       wrong_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            wrong_q <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            wrong_q <= wrong_d;
            pass_q  <= pass_d;
        end
    end

    assign wrong_inc = (wrong_q == 8'hFF) ? 8'hFF : wrong_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        stage_d      = stage_q;
        wrong_d      = wrong_q;
        pass_d       = pass_q;
        stage_onehot = '0;
        stage_idx    = '0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STAGE;
                    stage_d = '0;
                end
            end
            S_STAGE: begin
                stage_onehot = NUM_STAGES'(1) << stage_q;
                stage_idx    = stage_q;
                busy         = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (advance) begin
                    if (stage_q == PRE_IDX) begin
                        if (key == KEY_VALUE) begin
                            stage_d = LOCK_IDX;
`ifdef KEYED_FSM_RELOCK_EN
                            wrong_d = '0;
`endif
                        end else begin
                            state_d = S_SHADOW;
                        end
                    end else if (stage_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        stage_d = stage_q + IDX_W'(1);
                    end
                end
            end
            S_SHADOW: begin
                // Indistinguishable from the genuine lock stage on every output.
                stage_onehot = NUM_STAGES'(1) << LOCK_IDX;
                stage_idx    = LOCK_IDX;
                busy         = 1'b1;
                if (abort) begin
                    state_d = S_IDLE;
                end else if (advance) begin
                    wrong_d = wrong_inc;
                    if (wrong_inc < TRAP_LIM) begin
                        if (LOCK_IS_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_STAGE;
                            stage_d = SUCC_IDX;
                        end
                    end else begin
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: begin
                stage_onehot = NUM_STAGES'(1);
                busy         = 1'b1;
                if (abort) state_d = S_IDLE;
            end
            S_DONE: begin
                done    = 1'b1;
                pass_d  = pass_q + CNT_W'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pass_cnt = pass_q;

endmodule

// File: tb/tb_keyed_stage_fsm.sv
// Scoreboarded bench for keyed_stage_fsm at default parameters.
module tb_keyed_stage_fsm;

    localparam int NS   = 8;
    localparam int LOCK = 3;
    localparam int TRAP = 5;
    localparam logic [3:0] KEY_OK  = 4'hA;
    localparam logic [3:0] KEY_BAD = 4'h5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, advance = 1'b0, abort = 1'b0;
    logic [3:0] key = '0;
    logic [7:0] stage_onehot;
    logic [2:0] stage_idx;
    logic       busy, done;
    logic [7:0] pass_cnt;

    keyed_stage_fsm dut (
        .clk(clk), .rst(rst), .start(start), .advance(advance), .abort(abort), .key(key),
        .stage_onehot(stage_onehot), .stage_idx(stage_idx), .busy(busy), .done(done),
        .pass_cnt(pass_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
        logic       busy;
        logic       done;
        logic [7:0] pass;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // reference model state
    typedef enum int {M_IDLE, M_STG, M_SHD, M_TRP, M_DONE} mstate_t;
    mstate_t m_state;
    int      m_k, m_wrong, m_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e = '0;
        e.pass = m_pass[7:0];
        case (m_state)
            M_STG:  begin e.oh = 8'(1 << m_k); e.idx = 3'(m_k); e.busy = 1'b1; end
            M_SHD:  begin e.oh = 8'h08; e.idx = 3'd3; e.busy = 1'b1; end
            M_TRP:  begin e.oh = 8'h01; e.busy = 1'b1; end
            M_DONE: e.done = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    task automatic model_edge(input bit st, input bit adv, input bit ab, input logic [3:0] k);
        case (m_state)
            M_IDLE: if (st) begin m_state = M_STG; m_k = 0; end
            M_STG: begin
                if (ab) m_state = M_IDLE;
                else if (adv) begin
                    if (m_k == LOCK - 1) begin
                        if (k == KEY_OK) begin
                            m_k = LOCK;
`ifdef KEYED_FSM_RELOCK_EN
                            m_wrong = 0;
`endif
                        end else m_state = M_SHD;
                    end else if (m_k == NS - 1) m_state = M_DONE;
                    else m_k = m_k + 1;
                end
            end
            M_SHD: begin
                if (ab) m_state = M_IDLE;
                else if (adv) begin
                    if (m_wrong < 255) m_wrong = m_wrong + 1;
                    if (m_wrong < TRAP) begin m_state = M_STG; m_k = LOCK + 1; end
                    else m_state = M_TRP;
                end
            end
            M_TRP:  if (ab) m_state = M_IDLE;
            M_DONE: begin m_pass = (m_pass + 1) % 256; m_state = M_IDLE; end
            default: m_state = M_IDLE;
        endcase
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        if (q.size() == 0) begin
            chk({tag, "_qempty"}, 32'd0, 32'd1);
            return;
        end
        e = q.pop_front();
        chk({tag, "_oh"},   32'(stage_onehot), 32'(e.oh));
        chk({tag, "_idx"},  32'(stage_idx),    32'(e.idx));
        chk({tag, "_busy"}, 32'(busy),         32'(e.busy));
        chk({tag, "_done"}, 32'(done),         32'(e.done));
        chk({tag, "_pass"}, 32'(pass_cnt),     32'(e.pass));
    endtask

    // Drive one cycle of inputs, predict, then compare after the edge.
    task automatic cyc(input bit st, input bit adv, input bit ab, input logic [3:0] k, input string tag);
        start = st; advance = adv; abort = ab; key = k;
        model_edge(st, adv, ab, k);
        q.push_back(model_out());
        @(posedge clk);
        #1;
        compare_out(tag);
        start = 1'b0; advance = 1'b0; abort = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        start = 1'b0; advance = 1'b0; abort = 1'b0;
        #2;
        rst = 1'b1;
        m_state = M_IDLE; m_k = 0; m_wrong = 0; m_pass = 0;
        q.delete();
        #1;
        q.push_back(model_out());
        compare_out({tag, "_async"});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Full run; the trailing abort is ignored in DONE and clears a trap.
    task automatic run(input logic [3:0] k, input string tag);
        cyc(1, 0, 0, k, {tag, "_start"});
        for (int i = 0; i < NS; i++) cyc(0, 1, 0, k, tag);
        cyc(0, 0, 1, k, {tag, "_end"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        m_state = M_IDLE; m_k = 0; m_wrong = 0; m_pass = 0;
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: reset mid-run
        cyc(1, 0, 0, KEY_OK, "s1_start");
        cyc(0, 1, 0, KEY_OK, "s1_adv");
        do_reset("s1_rst");
        chk("s1_oh0", 32'(stage_onehot), 32'h0);
        chk("s1_busy0", 32'(busy), 32'h0);

        // 2: correct-key run, literal one-hot walk
        cyc(1, 0, 0, KEY_OK, "s2_start");
        chk("s2_oh_0", 32'(stage_onehot), 32'h01);
        for (int i = 1; i < NS; i++) begin
            cyc(0, 1, 0, KEY_OK, "s2_adv");
            chk("s2_oh_walk", 32'(stage_onehot), 32'(1 << i));
        end
        cyc(0, 1, 0, KEY_OK, "s2_last");
        chk("s2_done", 32'(done), 32'h1);
        cyc(0, 0, 0, KEY_OK, "s2_idle");
        chk("s2_done_low", 32'(done), 32'h0);
        chk("s2_pass", 32'(pass_cnt), 32'd1);
        chk("s2_busy", 32'(busy), 32'h0);

        // 3: five wrong-key runs; the fifth traps
        do_reset("s3_rst");
        for (int r = 0; r < 4; r++) run(KEY_BAD, "s3_run");
        chk("s3_pass4", 32'(pass_cnt), 32'd4);
        cyc(1, 0, 0, KEY_BAD, "s3_r5_start");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, KEY_BAD, "s3_r5_adv");
        chk("s3_shadow_oh", 32'(stage_onehot), 32'h08);
        cyc(0, 1, 0, KEY_BAD, "s3_r5_trap");
        chk("s3_trap_oh", 32'(stage_onehot), 32'h01);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, KEY_BAD, "s3_trap_hold");
        cyc(1, 0, 0, KEY_BAD, "s3_trap_start");
        chk("s3_trap_held", 32'(stage_onehot), 32'h01);
        chk("s3_trap_busy", 32'(busy), 32'h1);
        cyc(0, 0, 1, KEY_BAD, "s3_abort");
        chk("s3_idle", 32'(busy), 32'h0);
        chk("s3_pass_kept", 32'(pass_cnt), 32'd4);

        // 4: abort beats advance at stage 5
        do_reset("s4_rst");
        cyc(1, 0, 0, KEY_OK, "s4_start");
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, KEY_OK, "s4_adv");
        chk("s4_oh20", 32'(stage_onehot), 32'h20);
        cyc(1, 0, 0, KEY_OK, "s4_start_busy");
        chk("s4_oh20_hold", 32'(stage_onehot), 32'h20);
        cyc(0, 1, 1, KEY_OK, "s4_abort");
        chk("s4_idle", 32'(busy), 32'h0);
        cyc(0, 0, 0, KEY_OK, "s4_nodone");
        chk("s4_pass", 32'(pass_cnt), 32'd0);

        // 5: reset inside SHADOW restarts the wrong count
        do_reset("s5_rst0");
        for (int r = 0; r < 3; r++) run(KEY_BAD, "s5_pre");
        cyc(1, 0, 0, KEY_BAD, "s5_r4_start");
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, KEY_BAD, "s5_r4_adv");
        do_reset("s5_rst1");
        for (int r = 0; r < 4; r++) run(KEY_BAD, "s5_post");
        chk("s5_pass4", 32'(pass_cnt), 32'd4);

        // 6: correct key in between wrong-key batches
        do_reset("s6_rst");
        for (int r = 0; r < 3; r++) run(KEY_BAD, "s6_a");
        run(KEY_OK, "s6_ok");
        for (int r = 0; r < 4; r++) run(KEY_BAD, "s6_b");
`ifdef KEYED_FSM_RELOCK_EN
        chk("s6_pass", 32'(pass_cnt), 32'd8);
`else
        chk("s6_pass", 32'(pass_cnt), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
